instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction memory read request, level, held until imem_rvalid.
REQ-005 imem_addr  output  32  read address; equals pc while imem_req=1.
REQ-006 imem_rvalid  input  1  one-cycle pulse; imem_rdata valid.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 branch_taken  input  1  redirect request from execute; sampled every cycle.
REQ-009 branch_target  input  32  redirect address; valid when branch_taken=1.
REQ-010 inst_valid  output  1  inst/pc/partial_opcode valid to decode.
REQ-011 inst_ready  input  1  decode accepts the current instruction.
REQ-012 inst  output  32  held instruction word.
REQ-013 pc  output  32  address of the held instruction; also the current fetch address.
REQ-014 partial_opcode  output  5  inst[6:2], feeds the control unit.

Function
REQ-015 FSM states IDLE, FETCH, HOLD, DRAIN; at most one outstanding memory request.
REQ-016 IDLE: imem_req=0; unconditionally -> FETCH next cycle.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on imem_rvalid with branch_taken=0, capture imem_rdata into inst, set inst_valid=1, -> HOLD.
REQ-018 HOLD: imem_req=0, inst_valid=1, inst/pc stable; on inst_ready=1 with branch_taken=0, pc<=pc+4, inst_valid<=0, -> FETCH.
REQ-019 branch_taken has priority over inst_ready and imem_rvalid in every state.
REQ-020 branch_taken in HOLD: pc<=branch_target, inst_valid<=0, -> FETCH; held instruction discarded.
REQ-021 branch_taken in FETCH with imem_rvalid same cycle: response discarded, pc<=branch_target, remain FETCH.
REQ-022 branch_taken in FETCH without imem_rvalid: pc<=branch_target, imem_req<=0, -> DRAIN.
REQ-023 DRAIN: imem_req=0; next imem_rvalid discarded, -> FETCH; a further branch_taken in DRAIN overwrites pc, stays DRAIN.
REQ-024 branch_taken in IDLE: pc<=branch_target, -> FETCH.
REQ-025 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-026 partial_opcode is combinational from inst; latency fetch-address to inst_valid is memory latency + 1 cycle.

Reset
REQ-027 On rst: state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, misalign_err=0 (if present), immediately and asynchronously.
REQ-028 Reset mid-FETCH abandons the outstanding request; an imem_rvalid arriving in IDLE is ignored.

Configuration
REQ-029 Macro FETCH_MISALIGN_CHECK_EN defined: output misalign_err (1 bit, sticky until rst) is set when branch_taken=1 and branch_target[1:0]!=0; that redirect still occurs, with target[1:0] forced to 2'b00.
REQ-030 Macro undefined: no misalign_err port; branch_target[1:0] silently forced to 2'b00.

Structure
REQ-031 Shared package holds the FSM state enum, XLEN=32, INST_W=32, PC_STEP=4 and the opcode field slice constants used by the control unit.
REQ-032 One sub-module fetch_pc_gen (next-PC mux: pc+4 / branch_target / hold, with alignment masking); FSM and output registers stay in instruction_fetch.

Verification
REQ-033 Reset with RESET_PC=32'h100, memory 1-cycle latency, inst_ready=1 -> imem_addr sequence 0x100, 0x104, 0x108; inst_valid pulses per word; partial_opcode=5'b01100 for inst 32'h0020_81B3.
REQ-034 inst_ready=0 for 5 cycles in HOLD -> inst, pc, inst_valid unchanged; imem_req=0 throughout.
REQ-035 branch_taken with target 0x200 in FETCH, 3-cycle memory latency -> DRAIN, stale word discarded, next imem_addr=0x200, no inst_valid for the stale word.
REQ-036 branch_taken and imem_rvalid same cycle -> word dropped, imem_addr=target next cycle.
REQ-037 pc=32'hFFFF_FFFC accepted -> next imem_addr=32'h0000_0000.
REQ-038 With FETCH_MISALIGN_CHECK_EN, target 0x203 -> misalign_err=1 and stays 1, imem_addr=0x200; rst asserted mid-FETCH -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types and constants: FSM states, next-PC select, widths and the
// opcode field slice that decode/control consume.
package instruction_fetch_pkg;

   localparam int XLEN    = 32;
   localparam int INST_W  = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   // inst[OPC_MSB:OPC_LSB] is the opcode minus its always-11 low bits
   localparam int OPC_LSB = 2;
   localparam int OPC_MSB = 6;
   localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(PC_STEP - 32'd1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      DRAIN
   } fetch_state_e;

   typedef enum logic [1:0] {
      NPC_HOLD,
      NPC_STEP,
      NPC_BRANCH
   } npc_sel_e;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & ALIGN_MASK;
   endfunction

endpackage

// File: rtl/instruction_fetch_pc_gen.sv
// Next-PC mux: hold, sequential step (wraps mod 2^32) or word-aligned branch target.
// Optional FETCH_MISALIGN_CHECK_EN exposes whether the raw target was misaligned.
module fetch_pc_gen
   import instruction_fetch_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  npc_sel_e        sel,
   input  logic [XLEN-1:0] branch_target,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic            target_misaligned,
`endif
   output logic [XLEN-1:0] next_pc
);

   always_comb begin
      next_pc = pc;
      case (sel)
         NPC_STEP:   next_pc = pc + PC_STEP;
         NPC_BRANCH: next_pc = align_pc(branch_target);
         default:    next_pc = pc;
      endcase
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   assign target_misaligned = |branch_target[1:0];
`endif

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding imem read, holds the word until decode accepts,
// redirects on branch_taken. Optional FETCH_MISALIGN_CHECK_EN adds sticky misalign_err.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
   input  logic              clk,
   input  logic              rst,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic              misalign_err,
`endif
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              branch_taken,
   input  logic [XLEN-1:0]   branch_target,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [XLEN-1:0]   pc,
   output logic [OPC_W-1:0]  partial_opcode
);

   fetch_state_e      state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              inst_valid_q, inst_valid_d;
   logic              imem_req_q, imem_req_d;
   npc_sel_e          npc_sel;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic              misalign_err_q, misalign_err_d;
   logic              target_misaligned;
`endif

   fetch_pc_gen u_pc_gen (
      .pc                (pc_q),
      .sel               (npc_sel),
      .branch_target     (branch_target),
`ifdef FETCH_MISALIGN_CHECK_EN
      .target_misaligned (target_misaligned),
`endif
      .next_pc           (pc_d)
   );

   // branch_taken is checked first in every state so it wins over rvalid and ready
   always_comb begin
      state_d      = state_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      npc_sel      = NPC_HOLD;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (branch_taken) begin
               npc_sel = NPC_BRANCH;
            end
         end
         FETCH: begin
            if (branch_taken) begin
               npc_sel = NPC_BRANCH;
               state_d = imem_rvalid ? FETCH : DRAIN;
            end else if (imem_rvalid) begin
               inst_d       = imem_rdata;
               inst_valid_d = 1'b1;
               state_d      = HOLD;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               npc_sel      = NPC_BRANCH;
               inst_valid_d = 1'b0;
               state_d      = FETCH;
            end else if (inst_ready) begin
               npc_sel      = NPC_STEP;
               inst_valid_d = 1'b0;
               state_d      = FETCH;
            end
         end
         DRAIN: begin
            if (branch_taken) begin
               npc_sel = NPC_BRANCH;
            end
            // the stale response retires the outstanding request, redirect or not
            if (imem_rvalid) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d      = IDLE;
            inst_valid_d = 1'b0;
         end
      endcase
      imem_req_d = (state_d == FETCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         inst_valid_q <= 1'b0;
         imem_req_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         imem_req_q   <= imem_req_d;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   always_comb begin
      misalign_err_d = misalign_err_q | (branch_taken & target_misaligned);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_err_q <= 1'b0;
      end else begin
         misalign_err_q <= misalign_err_d;
      end
   end

   assign misalign_err = misalign_err_q;
`endif

   assign imem_req       = imem_req_q;
   assign imem_addr      = pc_q;
   assign inst_valid     = inst_valid_q;
   assign inst           = inst_q;
   assign pc             = pc_q;
   assign partial_opcode = inst_q[OPC_MSB:OPC_LSB];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: table-driven fetch stream plus directed stall, redirect,
// wrap, misalignment and reset sequences; a scoreboard queue pairs memory replies with decode output.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [4:0]  partial_opcode;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_err;
`endif

   instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
      .clk            (clk),
      .rst            (rst),
`ifdef FETCH_MISALIGN_CHECK_EN
      .misalign_err   (misalign_err),
`endif
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .pc             (pc),
      .partial_opcode (partial_opcode)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  opc;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;
      logic [4:0]  opc;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[4];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input logic [31:0] exp_addr);
      int i = 0;
      while (imem_req !== 1'b1 && i < 20) begin
         tick();
         i++;
      end
      chk("imem_req_seen", 32'(imem_req), 32'd1);
      chk("imem_addr", imem_addr, exp_addr);
   endtask

   // serve one read after lat cycles; push a scoreboard entry when decode should see it
   task automatic mem_reply(input logic [31:0] exp_addr, input logic [31:0] data,
                            input int lat, input logic push, input logic [4:0] opc);
      exp_t e;
      wait_req(exp_addr);
      repeat (lat) tick();
      chk("imem_req_held", 32'(imem_req), 32'd1);
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      if (push) begin
         e.pc   = exp_addr;
         e.inst = data;
         e.opc  = opc;
         sb.push_back(e);
      end
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
   endtask

   task automatic wait_inst();
      int   i = 0;
      exp_t e;
      while (inst_valid !== 1'b1 && i < 20) begin
         tick();
         i++;
      end
      chk("inst_valid_seen", 32'(inst_valid), 32'd1);
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_empty: got inst %h, expected no instruction", inst);
      end else begin
         e = sb.pop_front();
         chk("inst", inst, e.inst);
         chk("pc", pc, e.pc);
         chk("partial_opcode", 32'(partial_opcode), 32'(e.opc));
      end
   endtask

   initial begin
      vecs[0] = '{addr: 32'h0000_0100, data: 32'h0020_81B3, lat: 1, opc: 5'b01100};
      vecs[1] = '{addr: 32'h0000_0104, data: 32'h0000_0013, lat: 1, opc: 5'b00100};
      vecs[2] = '{addr: 32'h0000_0108, data: 32'h0000_006F, lat: 2, opc: 5'b11011};
      vecs[3] = '{addr: 32'h0000_010C, data: 32'h0000_0003, lat: 3, opc: 5'b00000};

      rst           = 1'b1;
      imem_rvalid   = 1'b0;
      imem_rdata    = 32'h0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      inst_ready    = 1'b1;
      repeat (3) tick();
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_pc", pc, 32'h0000_0100);
      chk("rst_inst", inst, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("rst_misalign_err", 32'(misalign_err), 32'd0);
`endif
      rst = 1'b0;
      chk("idle_imem_req", 32'(imem_req), 32'd0);

      // sequential stream
      for (int k = 0; k < 4; k++) begin
         mem_reply(vecs[k].addr, vecs[k].data, vecs[k].lat, 1'b1, vecs[k].opc);
         wait_inst();
         tick();
         chk("inst_valid_pulse", 32'(inst_valid), 32'd0);
      end

      // decode stall in HOLD
      inst_ready = 1'b0;
      mem_reply(32'h0000_0110, 32'h00A0_0093, 1, 1'b1, 5'b00100);
      wait_inst();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_inst_valid", 32'(inst_valid), 32'd1);
         chk("stall_inst", inst, 32'h00A0_0093);
         chk("stall_pc", pc, 32'h0000_0110);
         chk("stall_imem_req", 32'(imem_req), 32'd0);
      end
      inst_ready = 1'b1;
      tick();
      chk("stall_release_valid", 32'(inst_valid), 32'd0);

      // redirect during a 3-cycle read: DRAIN absorbs the stale word
      wait_req(32'h0000_0114);
      tick();
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0200;
      tick();
      branch_taken  = 1'b0;
      chk("drain_imem_req", 32'(imem_req), 32'd0);
      chk("drain_inst_valid", 32'(inst_valid), 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      chk("stale_inst_valid", 32'(inst_valid), 32'd0);
      mem_reply(32'h0000_0200, 32'h0000_0033, 1, 1'b1, 5'b01100);
      wait_inst();
      tick();

      // redirect coinciding with rvalid
      wait_req(32'h0000_0204);
      imem_rvalid   = 1'b1;
      imem_rdata    = 32'h1111_1111;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0300;
      tick();
      imem_rvalid   = 1'b0;
      branch_taken  = 1'b0;
      chk("same_cycle_req", 32'(imem_req), 32'd1);
      chk("same_cycle_addr", imem_addr, 32'h0000_0300);
      chk("same_cycle_valid", 32'(inst_valid), 32'd0);
      mem_reply(32'h0000_0300, 32'h0000_006F, 2, 1'b1, 5'b11011);
      wait_inst();
      tick();

      // redirect in HOLD wins over inst_ready; then pc wrap
      inst_ready = 1'b0;
      mem_reply(32'h0000_0304, 32'h0000_0013, 1, 1'b1, 5'b00100);
      wait_inst();
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      inst_ready    = 1'b1;
      tick();
      branch_taken  = 1'b0;
      chk("hold_branch_addr", imem_addr, 32'hFFFF_FFFC);
      chk("hold_branch_valid", 32'(inst_valid), 32'd0);
      mem_reply(32'hFFFF_FFFC, 32'h0000_0017, 1, 1'b1, 5'b00101);
      wait_inst();
      tick();
      inst_ready = 1'b0;
      mem_reply(32'h0000_0000, 32'h0000_0037, 1, 1'b1, 5'b01101);
      wait_inst();

      // misaligned redirect: low bits dropped
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("misalign_before", 32'(misalign_err), 32'd0);
`endif
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0203;
      tick();
      branch_taken  = 1'b0;
      chk("misalign_addr", imem_addr, 32'h0000_0200);
      chk("misalign_req", 32'(imem_req), 32'd1);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("misalign_set", 32'(misalign_err), 32'd1);
`endif
      inst_ready = 1'b1;
      mem_reply(32'h0000_0200, 32'h0000_0063, 1, 1'b1, 5'b11000);
      wait_inst();
      tick();
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("misalign_sticky", 32'(misalign_err), 32'd1);
`endif

      // asynchronous reset mid-FETCH, then a late rvalid in IDLE
      wait_req(32'h0000_0204);
      rst = 1'b1;
      #1;
      chk("async_rst_req", 32'(imem_req), 32'd0);
      chk("async_rst_valid", 32'(inst_valid), 32'd0);
      chk("async_rst_pc", pc, 32'h0000_0100);
      chk("async_rst_inst", inst, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("async_rst_misalign", 32'(misalign_err), 32'd0);
`endif
      tick();
      rst         = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h2222_2222;
      tick();
      imem_rvalid = 1'b0;
      chk("idle_rvalid_ignored", 32'(inst_valid), 32'd0);
      chk("post_rst_addr", imem_addr, 32'h0000_0100);
      mem_reply(32'h0000_0100, 32'h0020_81B3, 1, 1'b1, 5'b01100);
      wait_inst();
      tick();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
